// File: rtl/pkt_pkg.sv
// Shared codes, state encoding and helpers for the packet framing sequencer.
package pkt_pkg;

    localparam logic [8:0] K28_1 = 9'h13C;
    localparam logic [8:0] K28_5 = 9'h1BC;
    localparam logic [8:0] K23_7 = 9'h1F7;
    localparam logic [8:0] K28_7 = 9'h1FC;

    localparam int SYNC_LEN_DEF = 4;
    localparam int QUIET_DEF    = 10;
    localparam int CNT_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SYNC     = 3'd1,
        ST_BODY     = 3'd2,
        ST_INS_K237 = 3'd3,
        ST_INS_CRC  = 3'd4,
        ST_INS_EOP  = 3'd5,
        ST_QUIET    = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SEL_PASS = 2'd0,
        SEL_K237 = 2'd1,
        SEL_CRC  = 2'd2,
        SEL_EOP  = 2'd3
    } sel_t;

    // CRC bytes leave least significant first.
    function automatic logic [7:0] crc_lane(input logic [31:0] crc, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = crc[7:0];
            2'd1:    b = crc[15:8];
            2'd2:    b = crc[23:16];
            2'd3:    b = crc[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pkt_frame_seq_if.sv
// Symbol stream bundle: valid, 9-bit symbol ([8]=K) and start-of-packet marker.
interface pkt_frame_seq_if;
    logic       push;
    logic [8:0] data;
    logic       start;

    modport master (output push, data, start);
    modport slave  (input  push, data, start);
endinterface

// File: rtl/pkt_crc_mux.sv
// Output symbol selector: pass-through, K.23.7, one captured CRC byte lane, or K.28.5.
module pkt_crc_mux
    import pkt_pkg::*;
(
    input  sel_t        sel,
    input  logic [1:0]  lane,
    input  logic [8:0]  pass_data,
    input  logic [31:0] crc_cap,
    output logic [8:0]  mux_data
);

    // Symbol source selection
    always_comb begin
        mux_data = pass_data;
        case (sel)
            SEL_PASS: mux_data = pass_data;
            SEL_K237: mux_data = K23_7;
            SEL_CRC:  mux_data = {1'b0, crc_lane(crc_cap, lane)};
            SEL_EOP:  mux_data = K28_5;
            default:  mux_data = pass_data;
        endcase
    end

endmodule

// File: rtl/pkt_frame_seq.sv
// Packet framing sequencer: passes symbols to the encoder, gates the CRC engine,
// and on K.28.5 appends K.23.7, the CRC bytes and K.28.5, then holds a quiet window.
module pkt_frame_seq
    import pkt_pkg::*;
#(
    parameter int SYNC_LEN = SYNC_LEN_DEF,
    parameter int QUIET    = QUIET_DEF
) (
    input  logic               clk,
    input  logic               reset,
    pkt_frame_seq_if.slave     sym_in,
    pkt_frame_seq_if.master    sym_out,
    output logic               crc_clr,
    output logic               crc_en,
    output logic [7:0]         crc_byte,
    input  logic [31:0]        crc_result,
    output logic               busy,
    output logic               proto_err
);

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   sync_cnt_r, sync_nxt_s;
    // qcnt_r is 1 in the cycle after the K.28.5 input and counts every busy cycle
    logic [CNT_W-1:0]   qcnt_r;
    logic [31:0]        crc_cap_r;
    logic               err_s, pass_s, capture_s, busy_nxt_s, out_valid_s, quiet_done_s;
    logic               is_k281_s, is_k285_s, is_k287_s;
    logic [1:0]         lane_s;
    logic [8:0]         mux_data_s;
    sel_t               sel_s;

    assign is_k281_s    = (sym_in.data == K28_1);
    assign is_k285_s    = (sym_in.data == K28_5);
    assign is_k287_s    = (sym_in.data == K28_7);
    assign quiet_done_s = (qcnt_r >= CNT_W'(QUIET - 1));
    assign lane_s       = qcnt_r[1:0] - 2'd1;
    assign busy_nxt_s   = (state_nxt_s inside {ST_INS_K237, ST_INS_CRC, ST_INS_EOP, ST_QUIET});
    assign out_valid_s  = pass_s || (sel_s != SEL_PASS);

    // Next-state, framing checks and CRC gating
    always_comb begin
        state_nxt_s = state_r;
        sync_nxt_s  = sync_cnt_r;
        err_s       = 1'b0;
        pass_s      = 1'b0;
        capture_s   = 1'b0;
        sel_s       = SEL_PASS;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;
        crc_byte    = sym_in.data[7:0];
        case (state_r)
            ST_IDLE, ST_SYNC, ST_BODY: begin
                if (sym_in.push && sym_in.start) begin
                    pass_s  = 1'b1;
                    crc_clr = 1'b1;
                    if (is_k281_s) begin
                        err_s       = (state_r != ST_IDLE);
                        sync_nxt_s  = 8'd1;
                        state_nxt_s = (SYNC_LEN <= 1) ? ST_BODY : ST_SYNC;
                    end else begin
                        err_s       = 1'b1;
                        sync_nxt_s  = 8'd0;
                        state_nxt_s = ST_BODY;
                        crc_en      = !is_k285_s;
                    end
                end else if (sym_in.push && (state_r == ST_IDLE)) begin
                    pass_s = 1'b1;
                    err_s  = 1'b1;
                end else if (sym_in.push && (state_r == ST_SYNC)) begin
                    pass_s = 1'b1;
                    if (is_k281_s) begin
                        sync_nxt_s  = sync_cnt_r + 8'd1;
                        state_nxt_s = (sync_nxt_s >= CNT_W'(SYNC_LEN)) ? ST_BODY : ST_SYNC;
                    end else begin
                        // A short sync turns this symbol into the first body byte
                        err_s       = 1'b1;
                        state_nxt_s = ST_BODY;
                        crc_en      = !is_k285_s;
                    end
                end else if (sym_in.push && (state_r == ST_BODY)) begin
                    if (is_k285_s) begin
                        capture_s   = 1'b1;
                        sel_s       = SEL_K237;
                        state_nxt_s = ST_INS_K237;
                    end else begin
                        pass_s = 1'b1;
                        err_s  = is_k287_s;
                        crc_en = !is_k281_s;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_INS_K237: begin
                err_s       = sym_in.push;
                sel_s       = SEL_CRC;
                state_nxt_s = ST_INS_CRC;
            end
            ST_INS_CRC: begin
                err_s = sym_in.push;
                if (qcnt_r == 8'd5) begin
                    sel_s       = SEL_EOP;
                    state_nxt_s = ST_INS_EOP;
                end else begin
                    sel_s       = SEL_CRC;
                    state_nxt_s = ST_INS_CRC;
                end
            end
            ST_INS_EOP, ST_QUIET: begin
                err_s       = sym_in.push;
                state_nxt_s = quiet_done_s ? ST_IDLE : ST_QUIET;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    pkt_crc_mux u_mux (
        .sel       (sel_s),
        .lane      (lane_s),
        .pass_data (sym_in.data),
        .crc_cap   (crc_cap_r),
        .mux_data  (mux_data_s)
    );

    // State, counters, CRC capture and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            sync_cnt_r    <= 8'd0;
            qcnt_r        <= 8'd0;
            crc_cap_r     <= 32'd0;
            sym_out.push  <= 1'b0;
            sym_out.data  <= 9'd0;
            sym_out.start <= 1'b0;
            busy          <= 1'b0;
            proto_err     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            sync_cnt_r <= sync_nxt_s;
            if (capture_s) begin
                crc_cap_r <= crc_result;
                qcnt_r    <= 8'd1;
            end else if (busy) begin
                qcnt_r    <= qcnt_r + 8'd1;
            end else begin
                qcnt_r    <= 8'd0;
            end
            sym_out.push  <= out_valid_s;
            sym_out.data  <= out_valid_s ? mux_data_s : 9'd0;
            sym_out.start <= pass_s & sym_in.start;
            busy          <= busy_nxt_s;
            proto_err     <= err_s;
        end
    end

endmodule
